// File: rtl/apb_master_bridge.sv
// APB requester: turns single valid/ready read/write commands into APB SETUP/ACCESS
// transfers and returns read data or a timeout error on a one-cycle response strobe.
module apb_master_bridge #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              Psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    localparam int unsigned     CntW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLast = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d   = StSetup;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = req_write;
                    paddr_d   = req_addr;
                    pwdata_d  = req_wdata;
                    cnt_d     = '0;
                end
            end
            StSetup: begin
                state_d   = StAccess;
                penable_d = 1'b1;
            end
            StAccess: begin
                if (pready) begin
                    state_d     = StIdle;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // pready wins over a coincident timeout, hence the else branch
                    if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
                        state_d     = StIdle;
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q     <= StIdle;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready = Reset && (state_q == StIdle);
    assign Psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a small APB memory slave model.
module tb_apb_master_bridge;

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              Reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              Psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;

    logic              rd_force;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] mem [32];

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    apb_master_bridge #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .Reset    (Reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .Psel     (Psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pready   (pready),
        .prdata   (prdata)
    );

    // Memory slave: stores on a completed write, returns mem[paddr] unless overridden.
    always @(posedge clk) begin
        if (!Reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (Psel && penable && pready && pwrite) begin
            mem[paddr] <= pwdata;
        end
    end
    assign prdata = rd_force ? rd_val : mem[paddr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        Reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        pready    = 1'b1;
        rd_force  = 1'b0;
        rd_val    = '0;

        // Reset state
        tick();
        tick();
        chk("rst_psel", 64'(Psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_req_ready_low", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        Reset = 1'b1;
        #1;
        chk("rst_req_ready_high", 64'(req_ready), 64'd1);

        // Write 0xDEADBEEF to addr 5, no wait states
        send(1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        req_valid = 1'b0;
        chk("wr_setup_psel", 64'(Psel), 64'd1);
        chk("wr_setup_penable", 64'(penable), 64'd0);
        chk("wr_setup_pwrite", 64'(pwrite), 64'd1);
        chk("wr_setup_paddr", 64'(paddr), 64'd5);
        chk("wr_setup_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
        chk("wr_setup_ready", 64'(req_ready), 64'd0);
        tick();
        chk("wr_access_psel", 64'(Psel), 64'd1);
        chk("wr_access_penable", 64'(penable), 64'd1);
        chk("wr_access_paddr", 64'(paddr), 64'd5);
        chk("wr_access_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
        chk("wr_access_rsp", 64'(rsp_valid), 64'd0);
        tick();
        chk("wr_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("wr_rsp_err", 64'(rsp_err), 64'd0);
        chk("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("wr_done_psel", 64'(Psel), 64'd0);
        chk("wr_done_penable", 64'(penable), 64'd0);
        chk("wr_done_ready", 64'(req_ready), 64'd1);
        chk("wr_mem5", 64'(mem[5]), 64'hDEAD_BEEF);
        tick();
        chk("wr_rsp_pulse", 64'(rsp_valid), 64'd0);

        // Read addr 5 back from the slave memory
        send(1'b0, 5'd5, 32'h0);
        tick();
        req_valid = 1'b0;
        chk("rd_setup_pwrite", 64'(pwrite), 64'd0);
        tick();
        chk("rd_n2_rsp", 64'(rsp_valid), 64'd0);
        tick();
        chk("rd_n3_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rd_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
        chk("rd_err", 64'(rsp_err), 64'd0);
        tick();

        // Three wait states, then pready with prdata 0x1234
        rd_force = 1'b1;
        rd_val   = 32'h1234;
        pready   = 1'b0;
        send(1'b0, 5'd7, 32'h5555_AAAA);
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) pready = 1'b1;
            chk($sformatf("ws_penable_%0d", i), 64'(penable), 64'd1);
            chk($sformatf("ws_paddr_%0d", i), 64'(paddr), 64'd7);
            chk($sformatf("ws_pwdata_%0d", i), 64'(pwdata), 64'h5555_AAAA);
            chk($sformatf("ws_rsp_%0d", i), 64'(rsp_valid), 64'd0);
            tick();
        end
        chk("ws_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("ws_rdata", 64'(rsp_rdata), 64'h1234);
        chk("ws_err", 64'(rsp_err), 64'd0);
        tick();

        // Timeout: pready stuck low for 16 ACCESS cycles
        pready = 1'b0;
        send(1'b0, 5'd3, 32'h0);
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("to_penable_%0d", i), 64'(penable), 64'd1);
            chk($sformatf("to_rsp_%0d", i), 64'(rsp_valid), 64'd0);
            tick();
        end
        chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("to_rsp_err", 64'(rsp_err), 64'd1);
        chk("to_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("to_psel", 64'(Psel), 64'd0);
        chk("to_ready", 64'(req_ready), 64'd1);
        tick();
        chk("to_pulse", 64'(rsp_valid), 64'd0);
        chk("to_err_hold", 64'(rsp_err), 64'd1);

        // pready rises on the very edge that would time out: normal completion wins
        rd_val = 32'hCAFE_0016;
        send(1'b0, 5'd9, 32'h0);
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        pready = 1'b1;
        chk("tb_edge_rsp_before", 64'(rsp_valid), 64'd0);
        tick();
        chk("tb_edge_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("tb_edge_err", 64'(rsp_err), 64'd0);
        chk("tb_edge_rdata", 64'(rsp_rdata), 64'hCAFE_0016);
        tick();

        // Back-to-back: write addr 1 then read addr 2 with req_valid held
        rd_val = 32'h2222_2222;
        send(1'b1, 5'd1, 32'h0000_A5A5);
        tick();
        send(1'b0, 5'd2, 32'h0);
        chk("b2b_ready_n1", 64'(req_ready), 64'd0);
        tick();
        chk("b2b_ready_n2", 64'(req_ready), 64'd0);
        tick();
        chk("b2b_ready_n3", 64'(req_ready), 64'd1);
        chk("b2b_wr_rsp", 64'(rsp_valid), 64'd1);
        chk("b2b_mem1", 64'(mem[1]), 64'h0000_A5A5);
        tick();
        req_valid = 1'b0;
        chk("b2b_setup_psel", 64'(Psel), 64'd1);
        chk("b2b_setup_penable", 64'(penable), 64'd0);
        chk("b2b_setup_paddr", 64'(paddr), 64'd2);
        chk("b2b_setup_pwrite", 64'(pwrite), 64'd0);
        chk("b2b_gap_rsp", 64'(rsp_valid), 64'd0);
        tick();
        chk("b2b_gap2_rsp", 64'(rsp_valid), 64'd0);
        tick();
        chk("b2b_rd_rsp", 64'(rsp_valid), 64'd1);
        chk("b2b_rd_rdata", 64'(rsp_rdata), 64'h2222_2222);
        tick();

        // Reset asserted during ACCESS drops the transfer
        pready = 1'b0;
        send(1'b0, 5'd4, 32'h0);
        tick();
        req_valid = 1'b0;
        tick();
        chk("mr_in_access", 64'(penable), 64'd1);
        Reset = 1'b0;
        #1;
        chk("mr_ready_low", 64'(req_ready), 64'd0);
        tick();
        chk("mr_psel", 64'(Psel), 64'd0);
        chk("mr_penable", 64'(penable), 64'd0);
        chk("mr_rsp", 64'(rsp_valid), 64'd0);
        chk("mr_rdata", 64'(rsp_rdata), 64'd0);
        Reset  = 1'b1;
        pready = 1'b1;
        #1;
        chk("mr_ready_back", 64'(req_ready), 64'd1);
        tick();
        chk("mr_no_rsp", 64'(rsp_valid), 64'd0);
        chk("mr_idle_psel", 64'(Psel), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
